// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the fetch PC, buffers one redirect across stalls and keeps a CALL/RET stack.
// Build option: define PC_RAS_CIRCULAR_EN for a circular stack (a full push overwrites the oldest entry).
module pc_sequencer #(
    parameter int                ADDR_W    = 19,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int                RAS_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         stall,
    input  logic                         redirect_valid,
    input  logic [ADDR_W-1:0]            redirect_addr,
    input  logic                         call_valid,
    input  logic [ADDR_W-1:0]            call_target,
    input  logic                         ret_valid,
    output logic                         fetch_valid,
    output logic [ADDR_W-1:0]            fetch_pc,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         fault
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc_nxt;
    logic              pend_vld, pend_vld_nxt;
    logic [ADDR_W-1:0] pend_addr, pend_addr_nxt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [PTR_W-1:0]  sp, sp_nxt;
    logic              fault_nxt;
    logic              push_en;
    logic [ADDR_W-1:0] push_data;
    logic [ADDR_W-1:0] pop_data;
    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];

    function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
        return pc + ADDR_W'(1);
    endfunction

    function automatic logic is_full(input logic [CNT_W-1:0] c);
        return c == CNT_W'(RAS_DEPTH);
    endfunction

    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
        return is_full(c) ? c : c + CNT_W'(1);
    endfunction

    // sp points at the next free slot; the top of stack sits just below it
    assign pop_data    = ras_mem[sp - PTR_W'(1)];
    assign fetch_valid = (state == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        pc_nxt        = fetch_pc;
        pend_vld_nxt  = pend_vld;
        pend_addr_nxt = pend_addr;
        cnt_nxt       = ras_count;
        sp_nxt        = sp;
        fault_nxt     = fault;
        push_en       = 1'b0;
        push_data     = pc_inc(fetch_pc);
        case (state)
            BOOT: state_nxt = RUN;
            RUN: begin
                if (stall) begin
                    if (redirect_valid) begin
                        pend_vld_nxt  = 1'b1;
                        pend_addr_nxt = redirect_addr;
                    end
                end else if (pend_vld) begin
                    pc_nxt       = pend_addr;
                    pend_vld_nxt = 1'b0;
                end else if (redirect_valid) begin
                    pc_nxt = redirect_addr;
                end else if (ret_valid) begin
                    if (ras_count == '0) begin
                        state_nxt = FAULT;
                        fault_nxt = 1'b1;
                    end else begin
                        pc_nxt  = pop_data;
                        cnt_nxt = ras_count - CNT_W'(1);
                        sp_nxt  = sp - PTR_W'(1);
                    end
                end else if (call_valid) begin
`ifdef PC_RAS_CIRCULAR_EN
                    push_en = 1'b1;
                    pc_nxt  = call_target;
                    cnt_nxt = cnt_sat_inc(ras_count);
                    sp_nxt  = sp + PTR_W'(1);
`else
                    if (is_full(ras_count)) begin
                        state_nxt = FAULT;
                        fault_nxt = 1'b1;
                    end else begin
                        push_en = 1'b1;
                        pc_nxt  = call_target;
                        cnt_nxt = ras_count + CNT_W'(1);
                        sp_nxt  = sp + PTR_W'(1);
                    end
`endif
                end else begin
                    pc_nxt = pc_inc(fetch_pc);
                end
            end
            FAULT: ;
            default: state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc  <= RESET_PC;
            pend_vld  <= 1'b0;
            pend_addr <= '0;
            ras_count <= '0;
            sp        <= '0;
            fault     <= 1'b0;
        end else begin
            fetch_pc  <= pc_nxt;
            pend_vld  <= pend_vld_nxt;
            pend_addr <= pend_addr_nxt;
            ras_count <= cnt_nxt;
            sp        <= sp_nxt;
            fault     <= fault_nxt;
        end
    end

    // Stack storage is plain data: it survives reset, only the occupancy is cleared
    always_ff @(posedge clk) begin
        if (push_en) begin
            ras_mem[sp] <= push_data;
        end
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus a randomized run against a queue-based model.
module tb_pc_sequencer;
    localparam int ADDR_W    = 19;
    localparam int RAS_DEPTH = 8;
    localparam int unsigned PC_MASK = 32'h7FFFF;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              stall = 1'b0;
    logic              redirect_valid = 1'b0;
    logic [ADDR_W-1:0] redirect_addr = '0;
    logic              call_valid = 1'b0;
    logic [ADDR_W-1:0] call_target = '0;
    logic              ret_valid = 1'b0;
    logic              fetch_valid;
    logic [ADDR_W-1:0] fetch_pc;
    logic [3:0]        ras_count;
    logic              fault;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: plain flags, a PC, and a queue as the return stack
    bit          m_booted, m_faulted, m_pv;
    int unsigned m_pc, m_pend;
    int unsigned m_stack[$];

    pc_sequencer #(.ADDR_W(ADDR_W), .RESET_PC(19'd0), .RAS_DEPTH(RAS_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .call_valid(call_valid), .call_target(call_target), .ret_valid(ret_valid),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .ras_count(ras_count), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input bit st, input bit rv, input int unsigned ra,
                          input bit cv, input int unsigned ct, input bit tv);
        stall          = st;
        redirect_valid = rv;
        redirect_addr  = ADDR_W'(ra);
        call_valid     = cv;
        call_target    = ADDR_W'(ct);
        ret_valid      = tv;
    endtask

    task automatic model_reset();
        m_booted = 0; m_faulted = 0; m_pv = 0; m_pc = 0; m_pend = 0;
        m_stack.delete();
    endtask

    task automatic model_step();
        if (m_faulted) begin
        end else if (!m_booted) begin
            m_booted = 1;
        end else if (stall) begin
            if (redirect_valid) begin m_pv = 1; m_pend = redirect_addr; end
        end else if (m_pv) begin
            m_pc = m_pend; m_pv = 0;
        end else if (redirect_valid) begin
            m_pc = redirect_addr;
        end else if (ret_valid) begin
            if (m_stack.size() == 0) m_faulted = 1;
            else m_pc = m_stack.pop_back();
        end else if (call_valid) begin
            if (m_stack.size() == RAS_DEPTH) begin
`ifdef PC_RAS_CIRCULAR_EN
                void'(m_stack.pop_front());
                m_stack.push_back((m_pc + 1) & PC_MASK);
                m_pc = call_target;
`else
                m_faulted = 1;
`endif
            end else begin
                m_stack.push_back((m_pc + 1) & PC_MASK);
                m_pc = call_target;
            end
        end else begin
            m_pc = (m_pc + 1) & PC_MASK;
        end
    endtask

    task automatic check_model();
        chk("model_valid", fetch_valid, (m_booted && !m_faulted) ? 1 : 0);
        chk("model_pc",    fetch_pc,    m_pc);
        chk("model_cnt",   ras_count,   m_stack.size());
        chk("model_fault", fault,       m_faulted);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_model();
    endtask

    // Reset is asserted mid-cycle and checked before any clock edge
    task automatic reset_dut();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_pc",    fetch_pc,    0);
        chk("async_rst_valid", fetch_valid, 0);
        chk("async_rst_cnt",   ras_count,   0);
        chk("async_rst_fault", fault,       0);
        model_reset();
        set_in(0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        reset_dut();

        // Boot then sequential fetch
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("seq_valid", fetch_valid, 1);
            chk("seq_pc", fetch_pc, i);
        end

        // Redirect beats a simultaneous call
        set_in(0, 1, 150, 1, 300, 0); cycle();
        chk("redir_pc", fetch_pc, 150); chk("redir_cnt", ras_count, 0);
        set_in(0, 0, 0, 0, 0, 0); cycle();
        chk("redir_next", fetch_pc, 151);

        // Stall with two redirects, last one wins
        set_in(0, 1, 10, 0, 0, 0); cycle();
        set_in(1, 1, 200, 0, 0, 0); cycle(); chk("stall_hold1", fetch_pc, 10);
        set_in(1, 1, 250, 0, 0, 0); cycle(); chk("stall_hold2", fetch_pc, 10);
        set_in(1, 0, 0, 1, 500, 0); cycle(); chk("stall_hold3", fetch_pc, 10);
        set_in(0, 0, 0, 0, 0, 0); cycle(); chk("pend_pc", fetch_pc, 250);
        cycle(); chk("pend_next", fetch_pc, 251);

        // Nested call / ret
        set_in(0, 1, 20, 0, 0, 0); cycle();
        set_in(0, 0, 0, 1, 100, 0); cycle();
        chk("call1_pc", fetch_pc, 100); chk("call1_cnt", ras_count, 1);
        set_in(0, 0, 0, 0, 0, 0); cycle(); cycle();
        chk("pc102", fetch_pc, 102);
        set_in(0, 0, 0, 1, 400, 0); cycle();
        chk("call2_pc", fetch_pc, 400); chk("call2_cnt", ras_count, 2);
        set_in(0, 0, 0, 0, 0, 1); cycle(); chk("ret1_pc", fetch_pc, 103);
        cycle(); chk("ret2_pc", fetch_pc, 21); chk("ret2_cnt", ras_count, 0);

        // Fill the stack, then one more call
        for (int i = 0; i < RAS_DEPTH; i++) begin
            set_in(0, 0, 0, 1, 1000 + 16 * i, 0); cycle();
            chk("fill_cnt", ras_count, i + 1);
        end
        set_in(0, 0, 0, 1, 2000, 0); cycle();
`ifdef PC_RAS_CIRCULAR_EN
        chk("circ_fault", fault, 0); chk("circ_cnt", ras_count, 8); chk("circ_pc", fetch_pc, 2000);
        set_in(0, 0, 0, 0, 0, 1);
        for (int k = 7; k >= 0; k--) begin
            cycle(); chk("circ_ret_pc", fetch_pc, 1000 + 16 * k + 1);
        end
        cycle();
        chk("circ_uflow_fault", fault, 1); chk("circ_uflow_valid", fetch_valid, 0);
`else
        chk("ovf_fault", fault, 1); chk("ovf_valid", fetch_valid, 0); chk("ovf_pc", fetch_pc, 1112);
        set_in(0, 1, 77, 0, 0, 0); cycle();
        chk("ovf_frozen_pc", fetch_pc, 1112); chk("ovf_sticky", fault, 1);
`endif

        // Underflow from an empty stack
        reset_dut();
        cycle();
        set_in(0, 0, 0, 0, 0, 1); cycle();
        chk("uflow_fault", fault, 1); chk("uflow_valid", fetch_valid, 0); chk("uflow_pc", fetch_pc, 0);

        // Modulo wrap, then reset mid-operation
        reset_dut();
        cycle();
        set_in(0, 1, 32'h7FFFF, 0, 0, 0); cycle(); chk("wrap_top", fetch_pc, 32'h7FFFF);
        set_in(0, 0, 0, 0, 0, 0); cycle(); chk("wrap_zero", fetch_pc, 0); chk("wrap_nofault", fault, 0);
        cycle(); chk("wrap_one", fetch_pc, 1);
        reset_dut();

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            if (m_faulted && ($urandom % 3 == 0)) reset_dut();
            set_in($urandom % 4 == 0, $urandom % 5 == 0, $urandom & PC_MASK,
                   $urandom % 4 == 0, $urandom & PC_MASK, $urandom % 6 == 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
